mul_pipe: RTL and testbench

- Parametrised, pipelined integer multiplier for the EX stage, replacing the single-cycle 32x32 multiplier.
- Accepts one multiply per cycle under a valid/ready handshake. Supports low, signed-high and unsigned-high result selection, a pass-through tag and a pipeline flush for branch mispredict and exception.
- Fixed latency of STAGES cycles when not stalled.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_ppgen.sv | 29 ++
 rtl/mul_pipe.sv | 163 ++++++++++++++++
 tb/tb_mul_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined EX-stage multiplier.
package mul_pkg;

  typedef logic [1:0] mul_op_t;

  localparam mul_op_t MUL_OP_LO = 2'b00;
  localparam mul_op_t MUL_OP_HS = 2'b01;
  localparam mul_op_t MUL_OP_HU = 2'b10;

  localparam int unsigned MUL_STAGES_MIN = 2;
  localparam int unsigned MUL_STAGES_MAX = 4;

  // Only MULH treats its operands as signed; 2'b11 falls through to the MUL behaviour.
  function automatic logic op_is_signed(mul_op_t op);
    return op == MUL_OP_HS;
  endfunction

  function automatic logic op_is_high(mul_op_t op);
    return (op == MUL_OP_HS) || (op == MUL_OP_HU);
  endfunction

endpackage

// File: rtl/mul_ppgen.sv
// Four half-width signed partial products from (WIDTH+1)-bit extended operands.
module mul_ppgen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   a_x_i,
  input  logic [WIDTH:0]   b_x_i,
  output logic [WIDTH+1:0] pp_ll_o,
  output logic [WIDTH+1:0] pp_lh_o,
  output logic [WIDTH+1:0] pp_hl_o,
  output logic [WIDTH+1:0] pp_hh_o
);

  localparam int unsigned HW  = WIDTH / 2;
  localparam int unsigned PPW = WIDTH + 2;

  logic [PPW-1:0] a_lo, a_hi, b_lo, b_hi;

  // Low halves are unsigned; high halves carry the extension bit as their sign.
  assign a_lo = PPW'(a_x_i[HW-1:0]);
  assign b_lo = PPW'(b_x_i[HW-1:0]);
  assign a_hi = {{(PPW-HW-1){a_x_i[WIDTH]}}, a_x_i[WIDTH:HW]};
  assign b_hi = {{(PPW-HW-1){b_x_i[WIDTH]}}, b_x_i[WIDTH:HW]};

  assign pp_ll_o = a_lo * b_lo;
  assign pp_lh_o = a_lo * b_hi;
  assign pp_hl_o = a_hi * b_lo;
  assign pp_hh_o = a_hi * b_hi;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined WIDTHxWIDTH multiplier with valid/ready handshake, global stall and flush.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  mul_op_t            in_op_i,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_res_o,
  output logic [2*WIDTH-1:0] out_prod_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  localparam int unsigned HW  = WIDTH / 2;
  localparam int unsigned PPW = WIDTH + 2;
  localparam int unsigned PW  = 2 * WIDTH;

  if (STAGES < MUL_STAGES_MIN || STAGES > MUL_STAGES_MAX || (WIDTH % 2) != 0 || WIDTH < 8)
  begin : g_param_err
    $error("mul_pipe: illegal WIDTH/STAGES");
  end

  logic adv, in_acc;
  logic [STAGES:1] vld_q;

  // One enable for every stage: the pipe only moves when the output is free.
  assign adv         = !(vld_q[STAGES] && !out_ready_i);
  assign in_ready_o  = adv;
  assign in_acc      = in_valid_i && adv && !flush_i;
  assign out_valid_o = vld_q[STAGES];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-1:1], in_acc};
    end
  end

  // Stage 1: operand extension and partial products
  logic           sgn;
  logic [WIDTH:0] a_x, b_x;
  logic [PPW-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  assign sgn = op_is_signed(in_op_i);
  assign a_x = {sgn & in_a_i[WIDTH-1], in_a_i};
  assign b_x = {sgn & in_b_i[WIDTH-1], in_b_i};

  mul_ppgen #(
    .WIDTH(WIDTH)
  ) u_ppgen (
    .a_x_i  (a_x),
    .b_x_i  (b_x),
    .pp_ll_o(pp_ll),
    .pp_lh_o(pp_lh),
    .pp_hl_o(pp_hl),
    .pp_hh_o(pp_hh)
  );

  logic [PPW-1:0]   pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  mul_op_t          op1_q;
  logic [TAG_W-1:0] tag1_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      pp_ll_q <= pp_ll;
      pp_lh_q <= pp_lh;
      pp_hl_q <= pp_hl;
      pp_hh_q <= pp_hh;
      op1_q   <= in_op_i;
      tag1_q  <= in_tag_i;
    end
  end

  function automatic logic [PW-1:0] sext(logic [PPW-1:0] v);
    return {{(PW-PPW){v[PPW-1]}}, v};
  endfunction

  // Sums are taken modulo 2^(2*WIDTH); the true product always fits there.
  logic [PW-1:0] ps_lo_c, ps_hi_c;
  assign ps_lo_c = sext(pp_ll_q) + (sext(pp_hl_q) << HW);
  assign ps_hi_c = (sext(pp_lh_q) << HW) + (sext(pp_hh_q) << WIDTH);

  logic [PW-1:0]    fin_prod;
  mul_op_t          fin_op;
  logic [TAG_W-1:0] fin_tag;

  if (STAGES == 2) begin : g_s2
    assign fin_prod = ps_lo_c + ps_hi_c;
    assign fin_op   = op1_q;
    assign fin_tag  = tag1_q;
  end else begin : g_sum
    logic [PW-1:0]    ps_lo_q, ps_hi_q, full;
    mul_op_t          op2_q;
    logic [TAG_W-1:0] tag2_q;

    always_ff @(posedge clk) begin
      if (adv) begin
        ps_lo_q <= ps_lo_c;
        ps_hi_q <= ps_hi_c;
        op2_q   <= op1_q;
        tag2_q  <= tag1_q;
      end
    end

    assign full = ps_lo_q + ps_hi_q;

    if (STAGES == 3) begin : g_s3
      assign fin_prod = full;
      assign fin_op   = op2_q;
      assign fin_tag  = tag2_q;
    end else begin : g_s4
      logic [PW-1:0]    prod3_q;
      mul_op_t          op3_q;
      logic [TAG_W-1:0] tag3_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          prod3_q <= full;
          op3_q   <= op2_q;
          tag3_q  <= tag2_q;
        end
      end

      assign fin_prod = prod3_q;
      assign fin_op   = op3_q;
      assign fin_tag  = tag3_q;
    end
  end

  // Output stage: half selection and registered results
  logic [WIDTH-1:0] out_res_q;
  logic [PW-1:0]    out_prod_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_res_q  <= '0;
      out_prod_q <= '0;
      out_tag_q  <= '0;
    end else if (adv) begin
      out_res_q  <= op_is_high(fin_op) ? fin_prod[PW-1:WIDTH] : fin_prod[WIDTH-1:0];
      out_prod_q <= fin_prod;
      out_tag_q  <= fin_tag;
    end
  end

  assign out_res_o  = out_res_q;
  assign out_prod_o = out_prod_q;
  assign out_tag_o  = out_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe; STAGES=3 fully checked, STAGES=2/4 checked for latency and data.
module tb_mul_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  typedef struct {
    logic [TW-1:0]  tag;
    logic [W-1:0]   res;
    logic [2*W-1:0] prod;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;

  logic           ir2, ov2, ir3, ov3, ir4, ov4;
  logic [W-1:0]   res2, res3, res4;
  logic [2*W-1:0] prod2, prod3, prod4;
  logic [TW-1:0]  tag2, tag3, tag4;

  always #5 clk = ~clk;

  mul_pipe #(.WIDTH(W), .STAGES(3), .TAG_W(TW)) u_dut3 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir3),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag), .out_valid_o(ov3),
    .out_ready_i(out_ready), .out_res_o(res3), .out_prod_o(prod3), .out_tag_o(tag3)
  );

  mul_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir2),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag), .out_valid_o(ov2),
    .out_ready_i(out_ready), .out_res_o(res2), .out_prod_o(prod2), .out_tag_o(tag2)
  );

  mul_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) u_dut4 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir4),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag), .out_valid_o(ov4),
    .out_ready_i(out_ready), .out_res_o(res4), .out_prod_o(prod4), .out_tag_o(tag4)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   pop_cyc[$];
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, b,
                                 input logic [TW-1:0] tag);
    exp_t e;
    logic [63:0] ax, bx;
    if (op == 2'b01) begin
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
    end else begin
      ax = {32'b0, a};
      bx = {32'b0, b};
    end
    e.prod = ax * bx;
    e.res  = (op == 2'b01 || op == 2'b10) ? e.prod[63:32] : e.prod[31:0];
    e.tag  = tag;
    return e;
  endfunction

  // Monitor for the STAGES=3 instance: handshake, hold stability, scoreboard.
  logic           hold_pend = 1'b0;
  logic [W-1:0]   h_res;
  logic [2*W-1:0] h_prod;
  logic [TW-1:0]  h_tag;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      check_eq("in_ready", 64'(ir3), 64'(!(ov3 && !out_ready)));
      if (hold_pend) begin
        check_eq("hold_res", 64'(res3), 64'(h_res));
        check_eq("hold_prod", prod3, h_prod);
        check_eq("hold_tag", 64'(tag3), 64'(h_tag));
      end
      hold_pend <= ov3 && !out_ready && !flush;
      h_res     <= res3;
      h_prod    <= prod3;
      h_tag     <= tag3;
      if (ov3 && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("out_unexpected", 64'(ov3), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_tag", 64'(tag3), 64'(e.tag));
          check_eq("sb_res", 64'(res3), 64'(e.res));
          check_eq("sb_prod", prod3, e.prod);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Starts and ends just after a rising edge; in_valid stays high on return.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, b, input logic [TW-1:0] tag);
    logic done;
    int   t;
    done = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    while (!done && t < 50) begin
      @(negedge clk);
      if (ir3 && !flush) begin
        sb_q.push_back(model(op, a, b, tag));
        acc_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("send_accept", 64'(done), 64'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat_op(input logic [1:0] op, input logic [W-1:0] a, b, input logic [TW-1:0] tag);
    exp_t e;
    int l2, l3, l4, c2, c4;
    e = model(op, a, b, tag);
    l2 = 0; l3 = 0; l4 = 0; c2 = 0; c4 = 0;
    send(op, a, b, tag);
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (ov3 && l3 == 0) l3 = k;
      if (ov2) begin
        c2++;
        if (l2 == 0) begin
          l2 = k;
          check_eq("s2_res", 64'(res2), 64'(e.res));
          check_eq("s2_prod", prod2, e.prod);
          check_eq("s2_tag", 64'(tag2), 64'(e.tag));
        end
      end
      if (ov4) begin
        c4++;
        if (l4 == 0) begin
          l4 = k;
          check_eq("s4_res", 64'(res4), 64'(e.res));
          check_eq("s4_prod", prod4, e.prod);
          check_eq("s4_tag", 64'(tag4), 64'(e.tag));
        end
      end
    end
    check_eq("lat_s2", 64'(l2), 64'(2));
    check_eq("lat_s3", 64'(l3), 64'(3));
    check_eq("lat_s4", 64'(l4), 64'(4));
    check_eq("pulses_s2", 64'(c2), 64'(1));
    check_eq("pulses_s4", 64'(c4), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(ov3), 64'(0));
    check_eq("rst_ready", 64'(ir3), 64'(1));
    check_eq("rst_res", 64'(res3), 64'(0));
    check_eq("rst_prod", prod3, 64'(0));
    check_eq("rst_tag", 64'(tag3), 64'(0));
    rst = 1'b0;
    idle(1);

    // Latency and arithmetic on all three depths
    lat_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    lat_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    lat_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    lat_op(2'b01, 32'h8000_0000, 32'h0000_0002, 5'd10);
    lat_op(2'b10, 32'h8000_0000, 32'h0000_0002, 5'd11);
    lat_op(2'b00, 32'h8000_0000, 32'h0000_0002, 5'd12);
    lat_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
    lat_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 5'd14);

    // Back-to-back: four results in four consecutive cycles
    pop_cyc.delete();
    for (int i = 1; i <= 4; i++) send(2'(i - 1), $urandom, $urandom, 5'(i));
    idle(8);
    check_eq("b2b_count", 64'(pop_cyc.size()), 64'(4));
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check_eq("b2b_consec", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));

    // Output stall mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(20 + i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(10);
    check_eq("stall_drained", 64'(sb_q.size()), 64'(0));

    // Flush kills in-flight ops and the same-cycle input
    pop_cyc.delete();
    send(2'b00, 32'd3, 32'd5, 5'd1);
    send(2'b10, 32'd7, 32'd9, 5'd2);
    in_valid = 1'b1; flush = 1'b1; in_tag = 5'd3;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    send(2'b01, 32'hFFFF_FFF0, 32'd3, 5'd4);
    idle(8);
    check_eq("flush_count", 64'(pop_cyc.size()), 64'(1));
    if (pop_cyc.size() == 1) check_eq("flush_lat", 64'(pop_cyc[0] - acc_cyc), 64'(3));
    check_eq("flush_drained", 64'(sb_q.size()), 64'(0));

    // Reset with a held result and another op in flight
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, 5'd5);
    send(2'b00, 32'd17, 32'd19, 5'd6);
    idle(2);
    check_eq("pre_rst_ready", 64'(ir3), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid", 64'(ov3), 64'(0));
    check_eq("mid_rst_ready", 64'(ir3), 64'(1));
    check_eq("mid_rst_res", 64'(res3), 64'(0));
    check_eq("mid_rst_prod", prod3, 64'(0));
    check_eq("mid_rst_tag", 64'(tag3), 64'(0));
    check_eq("mid_rst_v2", 64'(ov2), 64'(0));
    check_eq("mid_rst_v4", 64'(ov4), 64'(0));
    rst = 1'b0;
    sb_q.delete();
    out_ready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
